axis_packet_snooper: RTL and testbench

//  Ingress stage directly upstream of packetmem: accepts packets on a 64-bit AXI-Stream

---
 rtl/axis_packet_snooper.sv | 145 ++++++++++++++
 tb/tb_axis_packet_snooper.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_snooper.sv
// AXI-Stream ingress for packetmem: writes each packet word-by-word into the granted buffer,
// truncating oversize packets to buffer capacity and draining the excess beats.
module axis_packet_snooper #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  ready_for_snooper,
    output logic [ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [63:0]           snooper_wr_data,
    output logic                  snooper_wr_en,
    output logic                  snooper_done,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  trunc_count
);

    localparam int unsigned DATA_W = 64;
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    typedef enum logic [2:0] {
        S_WAIT,
        S_STREAM,
        S_DRAIN,
        S_LAST,
        S_DONE,
        S_GAP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  trunc_q, trunc_d;
    logic                  tready_q, tready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  trunc_cnt_q, trunc_cnt_d;
    logic                  beat_c;

    assign beat_c = s_axis_tvalid & tready_q;

    // Next-state, write pipeline and statistics
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        trunc_d     = trunc_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        trunc_cnt_d = trunc_cnt_q;

        case (state_q)
            S_WAIT: begin
                ptr_d   = '0;
                trunc_d = 1'b0;
                if (ready_for_snooper) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (beat_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = s_axis_tdata;
                    ptr_d     = ADDR_WIDTH'(ptr_q + 1'b1);
                    if (s_axis_tlast) begin
                        state_d = S_LAST;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d = S_DRAIN;
                        trunc_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (beat_c && s_axis_tlast) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                // Counters advance together with the done pulse
                state_d   = S_DONE;
                done_d    = 1'b1;
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                if (trunc_q) begin
                    trunc_cnt_d = trunc_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                // packetmem's buffer select lags one cycle, so grant is not sampled here
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        tready_d = (state_d == S_STREAM) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            ptr_q       <= '0;
            trunc_q     <= 1'b0;
            tready_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            trunc_q     <= trunc_d;
            tready_q    <= tready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign snooper_wr_addr = wr_addr_q;
    assign snooper_wr_data = wr_data_q;
    assign snooper_wr_en   = wr_en_q;
    assign snooper_done    = done_q;
    assign pkt_count       = pkt_cnt_q;
    assign trunc_count     = trunc_cnt_q;

endmodule

// File: tb/tb_axis_packet_snooper.sv
// Randomized bench for axis_packet_snooper: a packet-level scoreboard predicts the buffer
// contents, truncation and counters for every completed packet.
module tb_axis_packet_snooper;

    localparam int unsigned AW  = 4;
    localparam int unsigned CW  = 32;
    localparam int          CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          ready_for_snooper;
    logic [AW-1:0] snooper_wr_addr;
    logic [63:0]   snooper_wr_data;
    logic          snooper_wr_en;
    logic          snooper_done;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] trunc_count;

    axis_packet_snooper #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .ready_for_snooper (ready_for_snooper),
        .snooper_wr_addr   (snooper_wr_addr),
        .snooper_wr_data   (snooper_wr_data),
        .snooper_wr_en     (snooper_wr_en),
        .snooper_done      (snooper_done),
        .pkt_count         (pkt_count),
        .trunc_count       (trunc_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Scoreboard state
    int          exp_len_q[$];
    logic [63:0] exp_words[$];
    int          got_addr[$];
    logic [63:0] got_data[$];
    int          exp_pkts     = 0;
    int          exp_trunc    = 0;
    int          acc_cnt      = 0;
    int          last_acc_cyc = -100;
    int          last_wr_cyc  = -100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: samples on the falling edge, scores each packet at its done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc > last_acc_cyc && cyc <= last_acc_cyc + 3)
                check("tready_after_last", 64'(s_axis_tready), 64'(0));
            if (s_axis_tvalid && s_axis_tready) begin
                acc_cnt++;
                if (s_axis_tlast) last_acc_cyc = cyc;
            end
            if (snooper_wr_en) begin
                got_addr.push_back(int'(snooper_wr_addr));
                got_data.push_back(snooper_wr_data);
                last_wr_cyc = cyc;
            end
            if (snooper_done) begin
                if (exp_len_q.size() == 0) begin
                    check("spurious_done", 64'(1), 64'(0));
                end else begin
                    int len;
                    int n;
                    len = exp_len_q.pop_front();
                    n   = (len > CAP) ? CAP : len;
                    check("done_latency", 64'(cyc - last_acc_cyc), 64'(2));
                    check("beats_accepted", 64'(acc_cnt), 64'(len));
                    check("write_count", 64'(got_addr.size()), 64'(n));
                    for (int i = 0; i < n; i++) begin
                        logic [63:0] ew;
                        ew = exp_words.pop_front();
                        if (i < got_addr.size()) begin
                            check("write_addr", 64'(got_addr[i]), 64'(i));
                            check("write_data", got_data[i], ew);
                        end
                    end
                    if (len <= CAP)
                        check("last_write_latency", 64'(last_wr_cyc - last_acc_cyc), 64'(1));
                    exp_pkts++;
                    if (len > CAP) exp_trunc++;
                    check("pkt_count", 64'(pkt_count), 64'(exp_pkts));
                    check("trunc_count", 64'(trunc_count), 64'(exp_trunc));
                end
                got_addr.delete();
                got_data.delete();
                acc_cnt = 0;
            end
        end
    end

    // Present one beat and hold it until accepted; returns on the falling edge after the handshake
    task automatic send_beat(input logic [63:0] d, input logic last);
        int t;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        t = 0;
        while (!s_axis_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("tready_timeout", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    // mode 0: no bubbles, 1: one idle cycle between beats, 2: random 0..2 idle cycles
    task automatic send_pkt(input int len, input int mode, input bit keep_valid);
        logic [63:0] words[$];
        exp_len_q.push_back(len);
        for (int i = 0; i < len; i++) begin
            words.push_back({$urandom, $urandom});
            if (i < CAP) exp_words.push_back(words[i]);
        end
        for (int i = 0; i < len; i++) begin
            int b;
            b = (i == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (b > 0) begin
                s_axis_tvalid = 1'b0;
                repeat (b) @(negedge clk);
            end
            send_beat(words[i], i == len - 1);
        end
        if (!keep_valid) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_len_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("idle_timeout", 64'(exp_len_q.size()), 64'(0));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit prev_keep;
        rst_n             = 1'b0;
        ready_for_snooper = 1'b0;
        s_axis_tvalid     = 1'b0;
        s_axis_tlast      = 1'b0;
        s_axis_tdata      = '0;
        repeat (3) @(negedge clk);
        check("rst_tready", 64'(s_axis_tready), 64'(0));
        check("rst_wr_en", 64'(snooper_wr_en), 64'(0));
        check("rst_done", 64'(snooper_done), 64'(0));
        check("rst_wr_addr", 64'(snooper_wr_addr), 64'(0));
        check("rst_wr_data", snooper_wr_data, 64'(0));
        check("rst_pkt_count", 64'(pkt_count), 64'(0));
        check("rst_trunc_count", 64'(trunc_count), 64'(0));
        rst_n = 1'b1;

        // No grant: stream is stalled
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hdead_beef_0000_0001;
        repeat (20) begin
            @(negedge clk);
            check("nogrant_tready", 64'(s_axis_tready), 64'(0));
            check("nogrant_wr_en", 64'(snooper_wr_en), 64'(0));
        end
        ready_for_snooper = 1'b1;
        @(negedge clk);
        check("grant_tready", 64'(s_axis_tready), 64'(1));
        send_pkt(3, 0, 1'b0);
        wait_idle();

        // Capacity boundaries
        send_pkt(20, 0, 1'b0);
        wait_idle();
        send_pkt(CAP, 0, 1'b0);
        wait_idle();
        send_pkt(CAP + 1, 2, 1'b0);
        wait_idle();
        send_pkt(CAP - 1, 0, 1'b0);
        wait_idle();
        send_pkt(1, 0, 1'b0);
        wait_idle();

        // Alternating valid, then back-to-back packets with valid held high
        send_pkt(4, 1, 1'b0);
        wait_idle();
        send_pkt(5, 0, 1'b1);
        send_pkt(3, 0, 1'b0);
        wait_idle();

        // Randomized packets
        prev_keep = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bit keep;
            keep = ($urandom_range(0, 3) == 0);
            if (!prev_keep && $urandom_range(0, 3) == 0) begin
                wait_idle();
                ready_for_snooper = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                ready_for_snooper = 1'b1;
            end
            send_pkt(int'($urandom_range(1, 40)), int'($urandom_range(0, 2)), keep);
            prev_keep = keep;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_idle();
        check("pending_pkts", 64'(exp_len_q.size()), 64'(0));

        // Mid-packet reset abandons the packet
        send_beat({$urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom}, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_tready", 64'(s_axis_tready), 64'(0));
        check("arst_wr_en", 64'(snooper_wr_en), 64'(0));
        check("arst_wr_addr", 64'(snooper_wr_addr), 64'(0));
        check("arst_wr_data", snooper_wr_data, 64'(0));
        check("arst_done", 64'(snooper_done), 64'(0));
        check("arst_pkt_count", 64'(pkt_count), 64'(0));
        s_axis_tvalid = 1'b0;
        got_addr.delete();
        got_data.delete();
        acc_cnt      = 0;
        last_acc_cyc = -100;
        exp_pkts     = 0;
        exp_trunc    = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_pkt(6, 2, 1'b0);
        wait_idle();
        check("final_pkt_count", 64'(pkt_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
